// File: rtl/cursor_ctrl.sv
// Selection-cursor controller: turns direction pulses into a target grid slot and
// slides the highlight's top-left corner toward it by STEP pixels per frame.
module cursor_ctrl #(
  parameter int unsigned COLS    = 3,
  parameter int unsigned ROWS    = 2,
  parameter int unsigned X0      = 64,
  parameter int unsigned Y0      = 96,
  parameter int unsigned PITCH_X = 320,
  parameter int unsigned PITCH_Y = 320,
  parameter int unsigned STEP    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_sel,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic [1:0]  col,
  output logic [1:0]  row,
  output logic        moving,
  output logic        sel_pulse,
  output logic [3:0]  sel_idx
);

  typedef enum logic {StIdle, StMoving} state_e;
  typedef enum logic [1:0] {DirUp, DirDown, DirLeft, DirRight} dir_e;

  localparam logic [1:0]  ColLast = 2'(COLS - 1);
  localparam logic [1:0]  RowLast = 2'(ROWS - 1);
  localparam logic [10:0] StepX   = 11'(STEP);
  localparam logic [9:0]  StepY   = 10'(STEP);

  state_e      state_q, state_d;
  logic [1:0]  col_q, col_d, row_q, row_d;
  logic [10:0] x_q, x_d, tx, x_step;
  logic [9:0]  y_q, y_d, ty, y_step;
  logic        pend_valid_q, pend_valid_d;
  dir_e        pend_dir_q, pend_dir_d;
  logic        sel_pulse_q, sel_pulse_d;
  logic [3:0]  sel_idx_q, sel_idx_d;

  logic        any_dir, mv_req;
  dir_e        new_dir, mv_dir;
  logic [1:0]  tgt_col, tgt_row;

  assign any_dir = btn_up | btn_down | btn_left | btn_right;

  // Same-cycle priority: up > down > left > right.
  always_comb begin
    if (btn_up)        new_dir = DirUp;
    else if (btn_down) new_dir = DirDown;
    else if (btn_left) new_dir = DirLeft;
    else               new_dir = DirRight;
  end

  // A fresh pulse beats a buffered one.
  assign mv_req = any_dir | pend_valid_q;
  assign mv_dir = any_dir ? new_dir : pend_dir_q;

  always_comb begin
    tgt_col = col_q;
    tgt_row = row_q;
    unique case (mv_dir)
      DirUp:    tgt_row = (row_q == 2'd0) ? RowLast : row_q - 2'd1;
      DirDown:  tgt_row = (row_q == RowLast) ? 2'd0 : row_q + 2'd1;
      DirLeft:  tgt_col = (col_q == 2'd0) ? ColLast : col_q - 2'd1;
      DirRight: tgt_col = (col_q == ColLast) ? 2'd0 : col_q + 2'd1;
      default:  ;
    endcase
  end

  assign tx = 11'(X0 + 32'(col_q) * PITCH_X);
  assign ty = 10'(Y0 + 32'(row_q) * PITCH_Y);

  // Pitches are multiples of STEP, so each axis lands exactly on its target.
  always_comb begin
    if (x_q < tx)      x_step = x_q + StepX;
    else if (x_q > tx) x_step = x_q - StepX;
    else               x_step = x_q;
    if (y_q < ty)      y_step = y_q + StepY;
    else if (y_q > ty) y_step = y_q - StepY;
    else               y_step = y_q;
  end

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    x_d          = x_q;
    y_d          = y_q;
    pend_valid_d = pend_valid_q;
    pend_dir_d   = pend_dir_q;
    sel_pulse_d  = 1'b0;
    sel_idx_d    = sel_idx_q;
    unique case (state_q)
      StIdle: begin
        if (mv_req) begin
          pend_valid_d = 1'b0;
          // Wrapping onto the current slot (single column/row) is a no-op.
          if (tgt_col != col_q || tgt_row != row_q) begin
            col_d   = tgt_col;
            row_d   = tgt_row;
            state_d = StMoving;
          end
        end else if (btn_sel) begin
          sel_pulse_d = 1'b1;
          sel_idx_d   = 4'(32'(row_q) * COLS + 32'(col_q));
        end
      end
      StMoving: begin
        if (any_dir) begin
          pend_valid_d = 1'b1;
          pend_dir_d   = new_dir;
        end
        if (frame_tick) begin
          x_d = x_step;
          y_d = y_step;
          if (x_step == tx && y_step == ty) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      col_q        <= 2'd0;
      row_q        <= 2'd0;
      x_q          <= 11'(X0);
      y_q          <= 10'(Y0);
      pend_valid_q <= 1'b0;
      pend_dir_q   <= DirUp;
      sel_pulse_q  <= 1'b0;
      sel_idx_q    <= 4'd0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      x_q          <= x_d;
      y_q          <= y_d;
      pend_valid_q <= pend_valid_d;
      pend_dir_q   <= pend_dir_d;
      sel_pulse_q  <= sel_pulse_d;
      sel_idx_q    <= sel_idx_d;
    end
  end

  assign x         = x_q;
  assign y         = y_q;
  assign col       = col_q;
  assign row       = row_q;
  assign moving    = (state_q == StMoving);
  assign sel_pulse = sel_pulse_q;
  assign sel_idx   = sel_idx_q;

endmodule

// File: tb/tb_cursor_ctrl.sv
// Directed bench for cursor_ctrl with default parameters (3x2 grid, pitch 320, step 16).
module tb_cursor_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_tick, btn_up, btn_down, btn_left, btn_right, btn_sel;
  logic [10:0] x;
  logic [9:0]  y;
  logic [1:0]  col, row;
  logic        moving, sel_pulse;
  logic [3:0]  sel_idx;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [5:0] F = 6'b100000;
  localparam logic [5:0] U = 6'b010000;
  localparam logic [5:0] D = 6'b001000;
  localparam logic [5:0] L = 6'b000100;
  localparam logic [5:0] R = 6'b000010;
  localparam logic [5:0] S = 6'b000001;

  cursor_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .frame_tick(frame_tick),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_sel   (btn_sel),
    .x         (x),
    .y         (y),
    .col       (col),
    .row       (row),
    .moving    (moving),
    .sel_pulse (sel_pulse),
    .sel_idx   (sel_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge: drive for one posedge, then release at the next negedge.
  task automatic step(input logic [5:0] v);
    {frame_tick, btn_up, btn_down, btn_left, btn_right, btn_sel} = v;
    @(negedge clk);
    {frame_tick, btn_up, btn_down, btn_left, btn_right, btn_sel} = '0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(F);
  endtask

  task automatic check_pos(input string tag, input int ex, input int ey, input int ec,
                           input int er, input int em);
    check({tag, ".x"}, int'(x), ex);
    check({tag, ".y"}, int'(y), ey);
    check({tag, ".col"}, int'(col), ec);
    check({tag, ".row"}, int'(row), er);
    check({tag, ".moving"}, int'(moving), em);
  endtask

  initial begin
    {frame_tick, btn_up, btn_down, btn_left, btn_right, btn_sel} = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_pos("rst", 64, 96, 0, 0, 0);
    check("rst.sel_pulse", int'(sel_pulse), 0);
    check("rst.sel_idx", int'(sel_idx), 0);
    reset = 1'b0;
    @(negedge clk);

    // frame_tick while idle does nothing
    ticks(2);
    check_pos("idle_tick", 64, 96, 0, 0, 0);

    // Single move right: 64 -> 384 over 20 ticks
    step(R);
    check_pos("right", 64, 96, 1, 0, 1);
    for (int k = 1; k <= 20; k++) begin
      step(F);
      check("right.x", int'(x), 64 + 16 * k);
      check("right.moving", int'(moving), (k < 20) ? 1 : 0);
    end
    check_pos("right.end", 384, 96, 1, 0, 0);

    // Back to col 0, then wrap left to col 2 (40 ticks)
    step(L);
    ticks(20);
    check_pos("back", 64, 96, 0, 0, 0);
    step(L);
    check_pos("wrap", 64, 96, 2, 0, 1);
    step(F);
    check("wrap.x1", int'(x), 80);
    ticks(38);
    check("wrap.x39", int'(x), 688);
    check("wrap.mv39", int'(moving), 1);
    step(F);
    check_pos("wrap.end", 704, 96, 2, 0, 0);

    // Down to row 1, then select -> idx 1*3+2 = 5
    step(D);
    ticks(20);
    check_pos("down", 704, 416, 2, 1, 0);
    step(S);
    check("sel.pulse", int'(sel_pulse), 1);
    check("sel.idx", int'(sel_idx), 5);
    step(0);
    check("sel.pulse_off", int'(sel_pulse), 0);
    check("sel.idx_hold", int'(sel_idx), 5);

    // Down from row 1 wraps to row 0; select while moving is dropped
    step(D);
    check_pos("wrap_dn", 704, 416, 2, 0, 1);
    step(S);
    check("sel_mv.pulse", int'(sel_pulse), 0);
    ticks(20);
    check_pos("wrap_dn.end", 704, 96, 2, 0, 0);
    check("sel_mv.none", int'(sel_pulse), 0);

    // Right from col 2 wraps to 0; then 0->1 with pending down, overwritten by right
    step(R);
    ticks(40);
    check_pos("to0", 64, 96, 0, 0, 0);
    step(R);
    ticks(5);
    step(D);
    step(R);
    check_pos("pend.hold", 144, 96, 1, 0, 1);
    ticks(15);
    check_pos("pend.arrive", 384, 96, 1, 0, 0);
    step(0);
    check_pos("pend.apply", 384, 96, 2, 0, 1);
    ticks(20);
    check_pos("pend.end", 704, 96, 2, 0, 0);

    // Up and left together: only the row changes (0 -> 1 by wrap)
    step(U | L);
    check_pos("simul", 704, 96, 2, 1, 1);
    ticks(20);
    check_pos("simul.end", 704, 416, 2, 1, 0);

    // Reset mid-move with a pending entry queued
    step(L);
    ticks(3);
    step(D);
    check_pos("pre_rst", 656, 416, 1, 1, 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_pos("async_rst", 64, 96, 0, 0, 0);
    check("async_rst.sel_pulse", int'(sel_pulse), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    ticks(4);
    step(0);
    check_pos("post_rst", 64, 96, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
